// File: rtl/d7seg_pkg.sv
// Shared constants and the hex-to-segment lookup for the 7-segment output stage.
package d7seg_pkg;

    localparam int HEX_BIT        = 0;
    localparam int BLINK_BIT      = 1;
    localparam int RATE_LSB       = 2;
    localparam int BRIGHT_LSB     = 4;
    localparam int BLINK_BASE_BIT = 4;

    // Segment order is {g,f,e,d,c,b,a}, active high.
    function automatic logic [6:0] hex2seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/d7seg_display_ctrl_tick_gen.sv
// Free-running prescaler producing a one-cycle blink tick every PRESCALE enabled cycles.
module tick_gen #(
    parameter int PRESCALE = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    output logic tick
);

    localparam int W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

    logic [W-1:0] pre_cnt;

    // Gated by ena so the blink counter holds while the display is disabled.
    assign tick = ena && (pre_cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (ena) begin
            if (pre_cnt == LAST) pre_cnt <= '0;
            else                 pre_cnt <= pre_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/d7seg_display_ctrl.sv
// 7-segment output stage: hex decode, PWM dimming, blinking, frame-aligned shadow update.
module d7seg_display_ctrl
    import d7seg_pkg::*;
#(
    parameter int PRESCALE  = 1000,
    parameter int PWM_WIDTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] data_i,
    input  logic [7:0] ctrl_i,
    output logic [7:0] d7seg_o,
    output logic       frame_o
);

    logic                 tick;
    logic [7:0]           blink_cnt;
    logic [PWM_WIDTH-1:0] pwm_cnt;
    logic [7:0]           data_sh;
    logic [7:0]           ctrl_sh;
    logic                 frame_end;
    logic [1:0]           rate;
    logic [2:0]           phase_idx;
    logic                 blink_phase;
    logic [3:0]           bright;
    logic                 bright_on;
    logic                 gate;
    logic [7:0]           pattern;

    tick_gen #(.PRESCALE(PRESCALE)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .ena  (ena),
        .tick (tick)
    );

    assign frame_end = ena && (pwm_cnt == '1);
    assign frame_o   = frame_end;

    // Blink and brightness are taken from the shadow copy so they only change per frame.
    assign rate        = ctrl_sh[RATE_LSB +: 2];
    assign phase_idx   = 3'(BLINK_BASE_BIT) + {1'b0, rate};
    assign blink_phase = blink_cnt[phase_idx];
    assign bright      = ctrl_sh[BRIGHT_LSB +: 4];
    assign bright_on   = (bright != 4'h0) && ((bright == 4'hF) || (pwm_cnt < bright));
    assign gate        = ena && bright_on && !(ctrl_sh[BLINK_BIT] && blink_phase);
    assign pattern     = ctrl_sh[HEX_BIT] ? {data_sh[7], hex2seg(data_sh[3:0])} : data_sh;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt <= '0;
            pwm_cnt   <= '0;
            data_sh   <= '0;
            ctrl_sh   <= '0;
            d7seg_o   <= '0;
        end else begin
            d7seg_o <= gate ? pattern : 8'h00;
            if (ena) begin
                pwm_cnt <= pwm_cnt + 1'b1;
                if (tick) blink_cnt <= blink_cnt + 1'b1;
                if (frame_end) begin
                    data_sh <= data_i;
                    ctrl_sh <= ctrl_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_d7seg_display_ctrl.sv
// Bench for d7seg_display_ctrl: cycle-accurate reference model feeding a scoreboard queue.
module tb_d7seg_display_ctrl;

    localparam int P = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b0;
    logic [7:0] data_i = 8'h00;
    logic [7:0] ctrl_i = 8'h00;
    logic [7:0] d7seg_o;
    logic       frame_o;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [7:0] exp_q[$];
    logic [6:0] lut[16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    d7seg_display_ctrl #(.PRESCALE(P), .PWM_WIDTH(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .data_i  (data_i),
        .ctrl_i  (ctrl_i),
        .d7seg_o (d7seg_o),
        .frame_o (frame_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    endtask

    // Reference model: state is just the number of enabled cycles since reset plus the
    // values latched at each 16th enabled cycle.
    int         k = 0;
    logic [7:0] m_data = 8'h00;
    logic [7:0] m_ctrl = 8'h00;

    always @(negedge clk) begin
        int pwm, bc, rate, b, phase;
        logic lit;
        logic [7:0] pat;
        if (rst) begin
            k = 0;
            m_data = 8'h00;
            m_ctrl = 8'h00;
        end else begin
            check("frame", frame_o, (ena && (k % 16 == 15)) ? 1 : 0);
            pwm   = k % 16;
            bc    = (k / P) % 256;
            rate  = int'(m_ctrl[3:2]);
            b     = int'(m_ctrl[7:4]);
            phase = (bc >> (4 + rate)) & 1;
            lit   = ena && (b != 0) && (b == 15 || pwm < b) && !(m_ctrl[1] && phase == 1);
            pat   = m_ctrl[0] ? {m_data[7], lut[m_data[3:0]]} : m_data;
            exp_q.push_back(lit ? pat : 8'h00);
            if (ena) begin
                if (k % 16 == 15) begin
                    m_data = data_i;
                    m_ctrl = ctrl_i;
                end
                k++;
            end
        end
    end

    // Monitor: the output register presents a new value after every edge.
    always @(posedge clk) begin
        logic [7:0] e;
        #1;
        if (!rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("seg", d7seg_o, e);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic count_lit(input logic [7:0] val, input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (d7seg_o == val) cnt++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        int found;
        logic seen;

        // Reset state
        #12;
        check("reset_seg", d7seg_o, 8'h00);
        check("reset_frame", frame_o, 1'b0);
        step();
        #1 rst = 1'b0;
        ena = 1'b1;

        // Hex 8 without dp lights 7F
        ctrl_i = 8'hF1;
        data_i = 8'h08;
        steps(40);
        check("pre_reset_7f", d7seg_o, 8'h7F);
        steps(5);
        #1 rst = 1'b1;
        #1;
        check("async_reset_seg", d7seg_o, 8'h00);
        check("async_reset_frame", frame_o, 1'b0);
        steps(2);
        #1 rst = 1'b0;
        found = 0;
        for (int i = 1; i <= 40 && found == 0; i++) begin
            @(negedge clk);
            if (frame_o) found = i;
        end
        check("first_frame_gap", found, 16);

        // Hex decode with dp
        ctrl_i = 8'hF1;
        data_i = 8'h8A;
        steps(34);
        check("hex_8a", d7seg_o, 8'hF7);
        for (int n = 0; n < 16; n++) begin
            data_i = {1'b1, 3'b000, 4'(n)};
            steps(34);
            check("hex_sweep", d7seg_o, {1'b1, lut[n]});
        end

        // Raw PWM: brightness 4 -> 4 of 16 cycles
        ctrl_i = 8'h40;
        data_i = 8'hFF;
        steps(34);
        count_lit(8'hFF, 64, cnt);
        check("pwm_b4_duty", cnt, 16);
        ctrl_i = 8'h00;
        steps(34);
        count_lit(8'h00, 32, cnt);
        check("pwm_b0_off", cnt, 32);

        // Glitch-free update
        ctrl_i = 8'hF0;
        data_i = 8'h55;
        steps(34);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = frame_o;
        end
        check("glitch_frame_seen", seen, 1'b1);
        step();
        data_i = 8'hAA;
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (d7seg_o == 8'h55) cnt++;
        end
        check("glitch_hold_55", cnt, 16);
        step();
        check("glitch_show_aa", d7seg_o, 8'hAA);

        // Blink: rate 0 and rate 3
        ctrl_i = 8'hF2;
        data_i = 8'hFF;
        steps(34);
        count_lit(8'hFF, 256, cnt);
        check("blink_rate0_on", cnt, 128);
        ctrl_i = 8'hFE;
        steps(34);
        count_lit(8'hFF, 1024, cnt);
        check("blink_rate3_on", cnt, 512);

        // Enable drop
        ctrl_i = 8'hF0;
        data_i = 8'h3C;
        steps(34);
        ena = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (d7seg_o == 8'h00 && frame_o == 1'b0) cnt++;
        end
        check("ena_low_blank", cnt, 10);
        ena = 1'b1;
        steps(40);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) data_i = 8'($urandom);
            if ($urandom_range(0, 15) == 0) ctrl_i = 8'($urandom);
            ena = ($urandom_range(0, 9) != 0);
            step();
        end
        ena = 1'b1;
        steps(3);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
